sccb_init_sequencer: RTL and testbench

Table-driven sequencer that configures the camera over SCCB after power-up. It walks an external synchronous register ROM of `{sub_addr, data}` entries and issues one 3-phase write per entry to the SCCB transceiver core. It handshakes on that core's `phase`/`phase_done` signals, inserts programmed delays, and reports done or timeout status to the top level. It sits between the top-level init trigger and the SCCB transceiver core.

---
 rtl/sccb_init_sequencer.sv | 133 +++++++++++++
 tb/tb_sccb_init_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_sequencer.sv
// sccb_init_sequencer: walks a {sub_addr, data} register ROM after power-up and issues
// one SCCB 3-phase write per entry, honouring delay entries, inter-write gaps and a write timeout.
module sccb_init_sequencer #(
    parameter int         SYS_CLK_FREQ   = 100_000_000,
    parameter logic [7:0] DEVICE_ADDR    = 8'h42,
    parameter int         ROM_DEPTH      = 256,
    parameter int         DELAY_CYCLES   = SYS_CLK_FREQ / 10,
    parameter int         TIMEOUT_CYCLES = SYS_CLK_FREQ / 50,
    parameter int         GAP_CYCLES     = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic [7:0]  o_main_addr,
    output logic [7:0]  o_sub_addr,
    output logic [7:0]  o_data,
    output logic [2:0]  o_phase,
    input  logic [2:0]  i_phase_done,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [7:0]  o_reg_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ROMWAIT, S_DECODE, S_ISSUE,
        S_WAITDONE, S_GAP, S_DELAY, S_DONE, S_ERROR
    } state_t;

    localparam logic [7:0] LAST_ADDR = 8'(ROM_DEPTH - 1);

    state_t      state_q, state_d;
    logic        start_q;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  sub_q, sub_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] cnt_q, cnt_d;
    logic        start_rise;
    logic        unused_phase_done;

    assign start_rise        = i_start & ~start_q;
    assign unused_phase_done = ^i_phase_done[2:1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            addr_q  <= '0;
            sub_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= i_start;
            addr_q  <= addr_d;
            sub_q   <= sub_d;
            data_q  <= data_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    // One shared counter: delay countdown, timeout count-up, or gap countdown.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sub_d   = sub_q;
        data_d  = data_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_rise) begin
                    addr_d  = '0;
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH:   state_d = S_ROMWAIT;
            S_ROMWAIT: state_d = S_DECODE;
            S_DECODE: begin
                if (i_rom_data == 16'hFFFF) begin
                    state_d = S_DONE;
                end else if (i_rom_data == 16'hFFF0) begin
                    cnt_d   = 32'(DELAY_CYCLES - 1);
                    state_d = S_DELAY;
                end else begin
                    sub_d   = i_rom_data[15:8];
                    data_d  = i_rom_data[7:0];
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAITDONE;
            S_WAITDONE: begin
                if (i_phase_done[0]) begin
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    cnt_d   = 32'(GAP_CYCLES);
                    state_d = S_GAP;
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // GAP spans GAP_CYCLES+1 cycles so the low time between writes is GAP_CYCLES+4.
            S_GAP, S_DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rom_addr  = addr_q;
    assign o_main_addr = DEVICE_ADDR;
    assign o_sub_addr  = sub_q;
    assign o_data      = data_q;
    assign o_phase     = {2'b00, (state_q == S_ISSUE) || (state_q == S_WAITDONE)};
    assign o_busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign o_done      = state_q == S_DONE;
    assign o_error     = state_q == S_ERROR;
    assign o_reg_count = count_q;
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb_sccb_init_sequencer: scoreboard bench; a ROM and SCCB core model feed either a full-depth
// or a 4-entry sequencer, and a monitor checks writes, phase timing and end-of-walk status.
module tb_sccb_init_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom [256];
    logic [15:0] rom_data = '0;
    logic        pd = 1'b0;
    int          lat = 30;
    int          k = 0;
    int          checks = 0, errors = 0;

    logic [15:0] exp_wr[$];
    int          exp_hi[$];
    int          exp_gap[$];
    logic [17:0] exp_end[$];

    logic [7:0] a0, ma0, s0, d0, c0, a4, ma4, s4, d4, c4;
    logic [2:0] p0, p4;
    logic       b0, dn0, e0, b4, dn4, e4;
    logic [7:0] m_addr, m_main, m_sub, m_data, m_cnt;
    logic [2:0] m_phase;
    logic       m_busy, m_done, m_error;

    assign m_addr  = sel ? a4 : a0;
    assign m_main  = sel ? ma4 : ma0;
    assign m_sub   = sel ? s4 : s0;
    assign m_data  = sel ? d4 : d0;
    assign m_cnt   = sel ? c4 : c0;
    assign m_phase = sel ? p4 : p0;
    assign m_busy  = sel ? b4 : b0;
    assign m_done  = sel ? dn4 : dn0;
    assign m_error = sel ? e4 : e0;

    sccb_init_sequencer #(.DELAY_CYCLES(50), .TIMEOUT_CYCLES(200), .GAP_CYCLES(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start & ~sel),
        .o_rom_addr(a0), .i_rom_data(rom_data), .o_main_addr(ma0), .o_sub_addr(s0),
        .o_data(d0), .o_phase(p0), .i_phase_done({2'b11, pd}), .o_busy(b0),
        .o_done(dn0), .o_error(e0), .o_reg_count(c0));

    sccb_init_sequencer #(.ROM_DEPTH(4), .DELAY_CYCLES(50), .TIMEOUT_CYCLES(200), .GAP_CYCLES(4)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start & sel),
        .o_rom_addr(a4), .i_rom_data(rom_data), .o_main_addr(ma4), .o_sub_addr(s4),
        .o_data(d4), .o_phase(p4), .i_phase_done({2'b11, pd}), .o_busy(b4),
        .o_done(dn4), .o_error(e4), .o_reg_count(c4));

    always @(posedge clk) rom_data <= rom[m_addr];

    // Core model: done pulses in the lat-th cycle after the ISSUE cycle; lat=0 never answers.
    always @(posedge clk) begin
        if (!m_phase[0]) begin
            k  <= 0;
            pd <= 1'b0;
        end else begin
            k  <= k + 1;
            pd <= (lat != 0) && (k + 1 == lat);
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    initial begin
        logic ph_prev, busy_prev, have_fall;
        int hi_n, lo_n;
        logic [15:0] w;
        logic [17:0] e;
        ph_prev = 1'b0; busy_prev = 1'b0; have_fall = 1'b0; hi_n = 0; lo_n = 0;
        forever begin
            @(negedge clk);
            if (busy_prev && !m_busy) begin
                if (exp_end.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL end_extra: walk ended with status %h, none expected", {m_done, m_error, m_cnt, m_addr});
                end else begin
                    e = exp_end.pop_front();
                    chk("end_status{done,err,cnt,addr}", 32'({m_done, m_error, m_cnt, m_addr}), 32'(e));
                end
            end
            if (m_busy && !busy_prev) have_fall = 1'b0;
            if (!rst_n) begin
                hi_n = 0; lo_n = 0; have_fall = 1'b0;
            end else if (m_phase[0] && !ph_prev) begin
                if (have_fall && exp_gap.size() > 0) chk("gap_cycles", 32'(lo_n), 32'(exp_gap.pop_front()));
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write_extra: got sub/data %h, none expected", {m_sub, m_data});
                end else begin
                    w = exp_wr.pop_front();
                    chk("write_sub_data", 32'({m_sub, m_data}), 32'(w));
                    chk("main_addr", 32'(m_main), 32'(8'h42));
                end
                hi_n = 1;
            end else if (m_phase[0]) begin
                hi_n++;
            end else if (ph_prev) begin
                if (exp_hi.size() > 0) chk("phase_high_cycles", 32'(hi_n), 32'(exp_hi.pop_front()));
                lo_n = 1;
                have_fall = 1'b1;
            end else begin
                lo_n++;
            end
            ph_prev = m_phase[0];
            busy_prev = m_busy;
        end
    end

    task automatic pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (m_busy && i < budget) begin @(negedge clk); i++; end
        if (m_busy) begin
            checks++; errors++;
            $display("FAIL walk_timeout: busy still 1 after %0d cycles, expected 0", budget);
        end
        @(negedge clk);
    endtask

    task automatic wait_phase(input int budget);
        int i = 0;
        while (!m_phase[0] && i < budget) begin @(negedge clk); i++; end
        if (!m_phase[0]) begin
            checks++; errors++;
            $display("FAIL phase_wait: phase 0 after %0d cycles, expected 1", budget);
        end
    endtask

    task automatic rom_basic();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
    endtask

    task automatic expect_basic(input int hi);
        exp_wr.push_back(16'h1280); exp_wr.push_back(16'h1101);
        exp_hi.push_back(hi); exp_hi.push_back(hi);
        exp_gap.push_back(8);
        exp_end.push_back({1'b1, 1'b0, 8'd2, 8'd2});
    endtask

    initial begin
        rom_basic();
        repeat (3) @(negedge clk);
        chk("rst_phase_busy_done_err", 32'({m_phase, m_busy, m_done, m_error}), 32'(0));
        chk("rst_addr_cnt", 32'({m_addr, m_cnt}), 32'(0));
        chk("rst_sub_data", 32'({m_sub, m_data}), 32'(0));
        chk("rst_main", 32'(m_main), 32'(8'h42));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // two writes then end marker
        lat = 30;
        expect_basic(31);
        pulse(); wait_idle(2000);

        // delay entry between writes: gap = 8 + 3 fetch cycles + 50 delay cycles
        rom[1] = 16'hFFF0; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
        exp_wr.push_back(16'h1280); exp_wr.push_back(16'h1101);
        exp_hi.push_back(31); exp_hi.push_back(31);
        exp_gap.push_back(61);
        exp_end.push_back({1'b1, 1'b0, 8'd2, 8'd3});
        pulse(); wait_idle(2000);

        // core never answers: timeout after ISSUE + 200 WAITDONE cycles
        rom_basic(); lat = 0;
        exp_wr.push_back(16'h1280); exp_hi.push_back(201);
        exp_end.push_back({1'b0, 1'b1, 8'd0, 8'd0});
        pulse(); wait_idle(2000);
        chk("err_phase", 32'(m_phase), 32'(0));
        chk("err_sticky", 32'(m_error), 32'(1));
        lat = 30;
        expect_basic(31);
        pulse(); wait_idle(2000);

        // start edge mid-write is ignored
        expect_basic(31);
        pulse(); wait_phase(50);
        repeat (3) @(negedge clk);
        pulse(); wait_idle(2000);

        // asynchronous reset during WAITDONE
        exp_wr.push_back(16'h1280);
        exp_end.push_back(18'h0);
        pulse(); wait_phase(50);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_phase_busy_done_err", 32'({m_phase, m_busy, m_done, m_error}), 32'(0));
        chk("arst_addr_cnt", 32'({m_addr, m_cnt}), 32'(0));
        chk("arst_sub_data", 32'({m_sub, m_data}), 32'(0));
        chk("arst_main", 32'(m_main), 32'(8'h42));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", 32'({m_phase, m_busy}), 32'(0));

        // 4-deep table without end marker stops at address 3
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rom[i] = {8'(i + 1), 8'(i + 1)};
            exp_wr.push_back({8'(i + 1), 8'(i + 1)});
            exp_hi.push_back(31);
            if (i > 0) exp_gap.push_back(8);
        end
        exp_end.push_back({1'b1, 1'b0, 8'd4, 8'd3});
        repeat (2) @(negedge clk);
        pulse(); wait_idle(2000);
        chk("depth4_addr_hold", 32'(m_addr), 32'(3));
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // done on the exact timeout cycle wins
        rom_basic(); lat = 200;
        expect_basic(201);
        pulse(); wait_idle(3000);

        // 256 writes, count saturates at 255, address stops at 255
        lat = 1;
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'(i), ~8'(i)};
            exp_wr.push_back({8'(i), ~8'(i)});
            exp_hi.push_back(2);
            if (i > 0) exp_gap.push_back(8);
        end
        exp_end.push_back({1'b1, 1'b0, 8'd255, 8'd255});
        pulse(); wait_idle(10000);

        repeat (3) @(negedge clk);
        chk("left_writes", 32'(exp_wr.size()), 32'(0));
        chk("left_hi", 32'(exp_hi.size()), 32'(0));
        chk("left_gaps", 32'(exp_gap.size()), 32'(0));
        chk("left_ends", 32'(exp_end.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
